branch_ctrl: RTL
================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Clk  in  1  single system clock; all state updates on rising edge.
REQ-002 Reset  in  1  asynchronous, active-low reset (Reset=0 clears state immediately).
REQ-003 Start  in  1  run request; sampled in IDLE and HALT.
REQ-004 Instr  in  9  current instruction word fetched at PC; [8:6] opcode, [3:0] LUT index.
REQ-005 AluZero  in  1  ALU result-is-zero indication for the current instruction.
REQ-006 FlagWe  in  1  write enable for the internal zero flag.
REQ-007 BranchRel  out  1  relative-branch request to program counter.
REQ-008 Zero  out  1  branch-condition-met qualifier to program counter.
REQ-009 Target  out  8  signed relative branch offset to program counter.
REQ-010 InstrValid  out  1  current Instr is architecturally executed this cycle.
REQ-011 Done  out  1  program halted.
REQ-012 CycleCnt  out  16  executed-cycle count since last start.

Function
REQ-013 FSM states IDLE, RUN, FLUSH, HALT; encoding defined in the shared package.
REQ-014 IDLE: Start=1 -> RUN, else stay.
REQ-015 RUN: HALT opcode (Instr=9'h1FF) -> HALT; taken branch -> FLUSH; else stay.
REQ-016 FLUSH: always -> RUN after exactly one cycle.
REQ-017 HALT: Start=1 -> RUN, else stay.
REQ-018 Opcodes: 3'b110 BRZ (taken if flag=1), 3'b101 BNZ (taken if flag=0); all others non-branch except 9'h1FF HALT.
REQ-019 Zero flag register: loads AluZero on rising edge when FlagWe=1 and state=RUN; held otherwise.
REQ-020 Branch decision uses the registered flag value; a same-cycle FlagWe affects only later instructions.
REQ-021 BranchRel=1 combinationally in RUN when opcode is BRZ or BNZ; 0 in all other states.
REQ-022 Zero=1 combinationally in RUN when the branch is taken; 0 otherwise.
REQ-023 Target = LUT[Instr[3:0]] in RUN for branch opcodes; 8'h00 otherwise.
REQ-024 LUT: 16 entries, 8-bit two's complement offsets; entry 0 = +1, entry 15 = -1 (8'hFF).
REQ-025 InstrValid=1 only in RUN; 0 in IDLE, FLUSH, HALT.
REQ-026 Done=1 only in HALT.
REQ-027 CycleCnt cleared to 0 on the IDLE->RUN or HALT->RUN edge; increments by 1 each cycle in RUN or FLUSH; saturates at 16'hFFFF (no wrap).
REQ-028 CycleCnt held in HALT (final value readable while Done=1).
REQ-029 HALT opcode has priority over flag write: FlagWe on the halting cycle still updates the flag.
REQ-030 Start ignored in RUN and FLUSH.

Reset
REQ-031 Reset=0 forces IDLE, flag=0, CycleCnt=0 asynchronously, regardless of Clk.
REQ-032 During reset: BranchRel=0, Zero=0, Target=8'h00, InstrValid=0, Done=0.
REQ-033 Reset asserted mid-FLUSH or mid-RUN abandons the branch; first post-reset state is IDLE.
REQ-034 Release of Reset takes effect on the next rising Clk; Start sampled from that edge.

Structure
REQ-035 Shared package branch_pkg holds state enum, opcode constants (OP_BRZ, OP_BNZ, HALT_WORD), and the 16-entry offset LUT constant.
REQ-036 Offset LUT as sub-module branch_lut (4-bit index in, 8-bit offset out, combinational); FSM, flag and counter in branch_ctrl.
REQ-037 No other sub-modules; no latches; no clock gating.

Verification
REQ-038 Reset=0 then 1, Start=0 for 5 cycles -> state IDLE, all outputs 0, CycleCnt=0.
REQ-039 Start pulse, FlagWe=1 AluZero=1, next Instr=9'b110_00_0000 -> BranchRel=1, Zero=1, Target=8'h01, next cycle InstrValid=0 (FLUSH), then RUN.
REQ-040 Flag=0, Instr=9'b110_00_1111 -> BranchRel=1, Zero=0, Target=8'hFF, no FLUSH, InstrValid stays 1.
REQ-041 Same cycle FlagWe=1 AluZero=1 with BNZ while flag=0 -> branch taken (Zero=1); following BRZ also taken.
REQ-042 Instr=9'h1FF after 10 RUN cycles -> Done=1, CycleCnt=10 held; Start -> Done=0, CycleCnt restarts at 0.
REQ-043 Reset=0 asserted between clock edges during FLUSH -> outputs 0 before next edge; after release, IDLE until Start.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch controller: FSM state encoding,
// branch opcodes, the halt word and the relative-offset table.
package branch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [2:0] OP_BRZ    = 3'b110;
  localparam logic [2:0] OP_BNZ    = 3'b101;
  localparam logic [8:0] HALT_WORD = 9'h1FF;

  // Two's complement offsets, entry 15 in the MSB slot down to entry 0.
  localparam logic [15:0][7:0] OFFSET_LUT = {
    8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'h80,
    8'h7F, 8'h20, 8'h10, 8'h08, 8'h04, 8'h03, 8'h02, 8'h01
  };

endpackage

// File: rtl/branch_lut.sv
// Branch offset lookup: 4-bit index to signed 8-bit relative offset.
// Purely combinational, no state.
module branch_lut
  import branch_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] offset
);

  assign offset = OFFSET_LUT[idx];

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: run/flush/halt sequencing, registered zero flag and
// executed-cycle counter; branch outputs are combinational from Instr in RUN.
module branch_ctrl
  import branch_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [8:0]  Instr,
  input  logic        AluZero,
  input  logic        FlagWe,
  output logic        BranchRel,
  output logic        Zero,
  output logic [7:0]  Target,
  output logic        InstrValid,
  output logic        Done,
  output logic [15:0] CycleCnt
);

  state_t      state, state_nxt;
  logic        flag;
  logic [15:0] cnt;
  logic [2:0]  opcode;
  logic        in_run;
  logic        is_branch;
  logic        taken;
  logic [7:0]  lut_offset;

  branch_lut u_lut (
    .idx    (Instr[3:0]),
    .offset (lut_offset)
  );

  assign opcode    = Instr[8:6];
  assign in_run    = (state == ST_RUN);
  assign is_branch = in_run && ((opcode == OP_BRZ) || (opcode == OP_BNZ));
  // Decision uses the registered flag; a same-cycle flag write lands later.
  assign taken     = is_branch && ((opcode == OP_BRZ) ? flag : !flag);

  always_comb begin
    state_nxt  = state;
    BranchRel  = 1'b0;
    Zero       = 1'b0;
    Target     = 8'h00;
    InstrValid = 1'b0;
    Done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        InstrValid = 1'b1;
        BranchRel  = is_branch;
        Zero       = taken;
        Target     = is_branch ? lut_offset : 8'h00;
        if (Instr == HALT_WORD) state_nxt = ST_HALT;
        else if (taken)         state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_nxt = ST_RUN;
      end
      ST_HALT: begin
        Done = 1'b1;
        if (Start) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                flag <= 1'b0;
    else if (in_run && FlagWe) flag <= AluZero;
  end

  // Cleared on entry to RUN from IDLE/HALT, saturating count while running.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= 16'h0000;
    end else if (((state == ST_IDLE) || (state == ST_HALT)) && Start) begin
      cnt <= 16'h0000;
    end else if ((in_run || (state == ST_FLUSH)) && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'h0001;
    end
  end

  assign CycleCnt = cnt;

endmodule
